keypad_scan_ctrl: RTL and testbench
===================================

KEYPAD_SCAN_CTRL -- requirements
Module: keypad_scan_ctrl

Interface
REQ-001 SHALL have parameter SCAN_DIV, default 1000, meaning clocks each row is driven before the scan advances (min 2).
REQ-002 SHALL have parameter DEB_CYCLES, default 20000, meaning consecutive stable clocks needed to accept a press or a release (min 2).
REQ-003 clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  reset, synchronous, active-low.
REQ-005 swc  input  4  keypad column sense, active-low; 1111 = no key.
REQ-006 swr  output  4  keypad row drive, one row low at a time.
REQ-007 key_code  output  4  code of the accepted key.
REQ-008 key_valid  output  1  key_code holds an unread key.
REQ-009 key_ready  input  1  consumer accepts; a transfer occurs on a clock where key_valid and key_ready are both 1.
REQ-010 key_down  output  1  high while a debounced key is held (HOLD or RELEASE state).
REQ-011 overrun  output  1  sticky flag: an accepted key was dropped.
REQ-012 ovr_clr  input  1  clears overrun.

Function
REQ-013 swr SHALL rotate 0111->1011->1101->1110->0111, advancing once every SCAN_DIV clocks in SCAN state only; any other swr value SHALL go to 0111 on the next advance.
REQ-014 States: SCAN, DEBOUNCE, HOLD, RELEASE; swr SHALL be frozen outside SCAN.
REQ-015 SCAN: on the last clock of each row dwell, swc with exactly one bit low SHALL capture {swr,swc} and enter DEBOUNCE; 1111 or two or more bits low SHALL be ignored and scanning continues.
REQ-016 DEBOUNCE: swc SHALL equal the captured column for DEB_CYCLES consecutive clocks, then push the code and enter HOLD. Any mismatch SHALL return to SCAN with swr advanced to the next row.
REQ-017 Code = 4*r + c. r = 0,1,2,3 for swr 0111,1011,1101,1110. c = 0,1,2,3 for swc 0111,1011,1101,1110. So 0111/0111 -> 0 and 1110/1110 -> 15.
REQ-018 HOLD: on swc == 1111, SHALL enter RELEASE; other changes of swc SHALL be ignored, so there is no second key and no repeat.
REQ-019 RELEASE: DEB_CYCLES consecutive clocks of swc == 1111 SHALL enter SCAN with swr advanced. Any non-1111 clock SHALL return to HOLD.
REQ-020 Each accepted press SHALL produce exactly one push; the push occurs on the clock DEBOUNCE exits to HOLD.
REQ-021 Output buffer (KEY_FIFO_EN undefined) is a single register. A push when empty, or in the same clock as a transfer, SHALL be stored; otherwise the push SHALL be dropped and overrun set.
REQ-022 key_code/key_valid SHALL update one clock after the push (latency 1); key_code SHALL hold its value while key_valid=1 and key_ready=0.
REQ-023 overrun SHALL be set by a drop and cleared by ovr_clr; a simultaneous drop and ovr_clr SHALL leave overrun=1.

Reset
REQ-024 rst_n=0 at a clock edge SHALL force: state SCAN, swr=0111, divider/debounce counters 0, key_code=0000, key_valid=0, key_down=0, overrun=0, buffer empty.
REQ-025 Reset SHALL take priority over every other input. A reset during DEBOUNCE, HOLD or RELEASE SHALL abandon the key without a push.

Configuration
REQ-026 With macro KEYPAD_SCAN_KEY_FIFO_EN defined, the output buffer SHALL be a 4-entry FIFO with key_code showing the head entry (first word fall-through). A push when full SHALL be dropped and set overrun, unless a transfer occurs in the same clock, in which case the push SHALL be stored. The empty/full flags SHALL be derived from read/write pointers that wrap from 3 to 0.
REQ-027 Without KEYPAD_SCAN_KEY_FIFO_EN, REQ-021 applies and no FIFO logic SHALL be present.

Verification (SCAN_DIV=4, DEB_CYCLES=8)
REQ-028 Hold swc=1011 while swr=1101 for 30 clocks, key_ready=1 -> after 8 stable clocks a single key_code=1001 (9) with key_valid pulse for 1 clock; key_down=1 until 8 clocks after release.
REQ-029 Bounce: swc=1110 at swr=0111 for 3 clocks then 1111 -> no push; swr continues with 1011.
REQ-030 Two columns low (swc=1100) -> ignored; swr keeps rotating every 4 clocks.
REQ-031 No FIFO, key_ready=0, press key 0 then key 15 -> key_code stays 0000, overrun=1. Then ovr_clr together with a third drop -> overrun stays 1.
REQ-032 FIFO build, key_ready=0, press 5 keys (1,2,3,4,5) -> FIFO holds 1,2,3,4 and overrun=1. Then key_ready=1 -> 1,2,3,4 delivered in order.
REQ-033 rst_n=0 for one clock during HOLD -> all outputs at reset values, swr=0111, no push after release.

Source files
------------

// File: rtl/keypad_scan_ctrl.sv
// Keypad scan controller: rotates the row drive, debounces a single key press
// and release, and hands each accepted key code to a consumer over a
// valid/ready handshake.
// Optional build macro KEYPAD_SCAN_KEY_FIFO_EN replaces the single-register
// output buffer with a 4-entry first-word-fall-through FIFO.
module keypad_scan_ctrl #(
    parameter int unsigned SCAN_DIV   = 1000,
    parameter int unsigned DEB_CYCLES = 20000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] swc,
    output logic [3:0] swr,
    output logic [3:0] key_code,
    output logic       key_valid,
    input  logic       key_ready,
    output logic       key_down,
    output logic       overrun,
    input  logic       ovr_clr
);

    localparam int unsigned DIV_W = $clog2(SCAN_DIV);
    localparam int unsigned DEB_W = $clog2(DEB_CYCLES);

    typedef enum logic [1:0] {
        ST_SCAN,
        ST_DEBOUNCE,
        ST_HOLD,
        ST_RELEASE
    } state_e;

    state_e             state_q;
    logic [DIV_W-1:0]   div_q;
    logic [DEB_W-1:0]   deb_q;
    logic [3:0]         swr_q;
    logic [3:0]         cap_col_q;
    logic [3:0]         cap_code_q;
    logic               key_down_q;
    logic               ovr_q;

    logic               push;
    logic               drop;
    logic               xfer;

    // Next row in the rotation; any unexpected pattern restarts at row 0.
    function automatic logic [3:0] next_row(input logic [3:0] r);
        case (r)
            4'b0111: next_row = 4'b1011;
            4'b1011: next_row = 4'b1101;
            4'b1101: next_row = 4'b1110;
            default: next_row = 4'b0111;
        endcase
    endfunction

    // Index of the single low bit, counting from the MSB.
    function automatic logic [1:0] low_idx(input logic [3:0] v);
        case (v)
            4'b0111: low_idx = 2'd0;
            4'b1011: low_idx = 2'd1;
            4'b1101: low_idx = 2'd2;
            default: low_idx = 2'd3;
        endcase
    endfunction

    // True when exactly one column line is pulled low.
    function automatic logic one_low(input logic [3:0] v);
        logic [3:0] n;
        n       = ~v;
        one_low = (n != 4'd0) && ((n & (n - 4'd1)) == 4'd0);
    endfunction

    // Scan / debounce / hold / release sequencing with registered outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= ST_SCAN;
            swr_q      <= 4'b0111;
            div_q      <= '0;
            deb_q      <= '0;
            cap_col_q  <= 4'b1111;
            cap_code_q <= 4'd0;
            key_down_q <= 1'b0;
        end else begin
            case (state_q)
                ST_SCAN: begin
                    if (div_q == DIV_W'(SCAN_DIV - 1)) begin
                        div_q <= '0;
                        if (one_low(swc)) begin
                            cap_col_q  <= swc;
                            cap_code_q <= {low_idx(swr_q), low_idx(swc)};
                            deb_q      <= '0;
                            state_q    <= ST_DEBOUNCE;
                        end else begin
                            swr_q <= next_row(swr_q);
                        end
                    end else begin
                        div_q <= div_q + DIV_W'(1);
                    end
                end
                ST_DEBOUNCE: begin
                    if (swc != cap_col_q) begin
                        swr_q   <= next_row(swr_q);
                        div_q   <= '0;
                        state_q <= ST_SCAN;
                    end else if (deb_q == DEB_W'(DEB_CYCLES - 1)) begin
                        key_down_q <= 1'b1;
                        state_q    <= ST_HOLD;
                    end else begin
                        deb_q <= deb_q + DEB_W'(1);
                    end
                end
                ST_HOLD: begin
                    if (swc == 4'b1111) begin
                        deb_q   <= '0;
                        state_q <= ST_RELEASE;
                    end
                end
                ST_RELEASE: begin
                    if (swc != 4'b1111) begin
                        state_q <= ST_HOLD;
                    end else if (deb_q == DEB_W'(DEB_CYCLES - 1)) begin
                        swr_q      <= next_row(swr_q);
                        div_q      <= '0;
                        key_down_q <= 1'b0;
                        state_q    <= ST_SCAN;
                    end else begin
                        deb_q <= deb_q + DEB_W'(1);
                    end
                end
                default: state_q <= ST_SCAN;
            endcase
        end
    end

    // One push on the clock the debounce window completes.
    assign push = (state_q == ST_DEBOUNCE) && (swc == cap_col_q) &&
                  (deb_q == DEB_W'(DEB_CYCLES - 1));

`ifdef KEYPAD_SCAN_KEY_FIFO_EN
    logic [3:0] mem_q [4];
    logic [2:0] wr_q;       // {lap, index}
    logic [2:0] rd_q;       // {lap, index}
    logic       empty;
    logic       full;

    assign empty = (wr_q == rd_q);
    assign full  = (wr_q[1:0] == rd_q[1:0]) && (wr_q[2] != rd_q[2]);
    assign xfer  = !empty && key_ready;
    assign drop  = push && full && !xfer;

    // FIFO storage and pointers; the head entry is presented directly.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_q <= 3'd0;
            rd_q <= 3'd0;
            for (int i = 0; i < 4; i++) begin
                mem_q[i] <= 4'd0;
            end
        end else begin
            if (push && (!full || xfer)) begin
                mem_q[wr_q[1:0]] <= cap_code_q;
                wr_q             <= wr_q + 3'd1;
            end
            if (xfer) begin
                rd_q <= rd_q + 3'd1;
            end
        end
    end

    assign key_valid = !empty;
    assign key_code  = mem_q[rd_q[1:0]];
`else
    logic [3:0] code_q;
    logic       valid_q;

    assign xfer = valid_q && key_ready;
    assign drop = push && valid_q && !xfer;

    // Single-entry holding register; accepts a push when empty or draining.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            code_q  <= 4'd0;
            valid_q <= 1'b0;
        end else if (push && (!valid_q || xfer)) begin
            code_q  <= cap_code_q;
            valid_q <= 1'b1;
        end else if (xfer) begin
            valid_q <= 1'b0;
        end
    end

    assign key_valid = valid_q;
    assign key_code  = code_q;
`endif

    // Sticky overrun; a drop outranks a clear in the same clock.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ovr_q <= 1'b0;
        end else if (drop) begin
            ovr_q <= 1'b1;
        end else if (ovr_clr) begin
            ovr_q <= 1'b0;
        end
    end

    assign swr      = swr_q;
    assign key_down = key_down_q;
    assign overrun  = ovr_q;

endmodule

// File: tb/tb_keypad_scan_ctrl.sv
// Testbench for keypad_scan_ctrl: reference model compared every cycle, a
// table of key presses with hand-derived codes, directed corner sequences
// and a randomized phase. Honours KEYPAD_SCAN_KEY_FIFO_EN for buffer depth.
module tb_keypad_scan_ctrl;

    localparam int SD = 4;
    localparam int DB = 8;
`ifdef KEYPAD_SCAN_KEY_FIFO_EN
    localparam int DEPTH = 4;
`else
    localparam int DEPTH = 1;
`endif

    localparam int P_SCAN = 0;
    localparam int P_DEB  = 1;
    localparam int P_HOLD = 2;
    localparam int P_REL  = 3;

    logic       clk       = 1'b0;
    logic       rst_n     = 1'b0;
    logic [3:0] swc       = 4'hF;
    logic       key_ready = 1'b0;
    logic       ovr_clr   = 1'b0;
    logic [3:0] swr;
    logic [3:0] key_code;
    logic       key_valid;
    logic       key_down;
    logic       overrun;

    always #5 clk = ~clk;

    keypad_scan_ctrl #(.SCAN_DIV(SD), .DEB_CYCLES(DB)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .swc       (swc),
        .swr       (swr),
        .key_code  (key_code),
        .key_valid (key_valid),
        .key_ready (key_ready),
        .key_down  (key_down),
        .overrun   (overrun),
        .ovr_clr   (ovr_clr)
    );

    int n_checks = 0;
    int n_errors = 0;
    int got_q[$];

    // Reference model state: row index, phase, counters and a code queue.
    int         m_phase = P_SCAN;
    int         m_row   = 0;
    int         m_div   = 0;
    int         m_cnt   = 0;
    int         m_code  = 0;
    logic [3:0] m_cap   = 4'hF;
    bit         m_ovr   = 1'b0;
    int         m_q[$];

    function automatic int zeros(input logic [3:0] v);
        int n = 0;
        for (int i = 0; i < 4; i++) if (!v[i]) n++;
        return n;
    endfunction

    function automatic int low_pos(input logic [3:0] v);
        for (int i = 0; i < 4; i++) if (!v[i]) return 3 - i;
        return 0;
    endfunction

    function automatic logic [3:0] row_pat(input int r);
        logic [3:0] v = 4'hF;
        v[3 - r] = 1'b0;
        return v;
    endfunction

    always @(posedge clk) begin : ref_model
        bit push;
        bit drop;
        bit xfer;
        push = 1'b0;
        drop = 1'b0;
        if (!rst_n) begin
            m_phase = P_SCAN; m_row = 0; m_div = 0; m_cnt = 0; m_ovr = 1'b0;
            m_q.delete();
        end else begin
            xfer = (m_q.size() > 0) && key_ready;
            case (m_phase)
                P_SCAN: begin
                    if (m_div == SD - 1) begin
                        m_div = 0;
                        if (zeros(swc) == 1) begin
                            m_cap = swc; m_code = 4 * m_row + low_pos(swc);
                            m_cnt = 0; m_phase = P_DEB;
                        end else m_row = (m_row + 1) % 4;
                    end else m_div++;
                end
                P_DEB: begin
                    if (swc != m_cap) begin
                        m_phase = P_SCAN; m_row = (m_row + 1) % 4; m_div = 0;
                    end else if (m_cnt == DB - 1) begin
                        push = 1'b1; m_phase = P_HOLD;
                    end else m_cnt++;
                end
                P_HOLD: if (swc == 4'hF) begin m_phase = P_REL; m_cnt = 0; end
                default: begin
                    if (swc != 4'hF) m_phase = P_HOLD;
                    else if (m_cnt == DB - 1) begin
                        m_phase = P_SCAN; m_row = (m_row + 1) % 4; m_div = 0;
                    end else m_cnt++;
                end
            endcase
            if (xfer) void'(m_q.pop_front());
            if (push) begin
                if (m_q.size() < DEPTH) m_q.push_back(m_code);
                else drop = 1'b1;
            end
            if (drop) m_ovr = 1'b1;
            else if (ovr_clr) m_ovr = 1'b0;
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Advance one clock, logging transfers, then compare against the model.
    task automatic tick();
        if (rst_n && key_valid && key_ready) got_q.push_back(int'(key_code));
        @(negedge clk);
        chk("swr", int'(swr), int'(row_pat(m_row)));
        chk("key_valid", int'(key_valid), int'(m_q.size() > 0));
        chk("key_down", int'(key_down), int'(m_phase == P_HOLD || m_phase == P_REL));
        chk("overrun", int'(overrun), int'(m_ovr));
        if (m_q.size() > 0) chk("key_code", int'(key_code), m_q[0]);
    endtask

    // Return at the first clock of a fresh dwell on the given row.
    task automatic wait_row_start(input logic [3:0] row);
        int guard = 0;
        while (swr == row && guard < 60) begin tick(); guard++; end
        while (swr != row && guard < 60) begin tick(); guard++; end
        chk("row_wait_timeout", int'(guard < 60), 1);
    endtask

    task automatic press(input logic [3:0] row, input logic [3:0] col,
                         input int hold, input int rel);
        swc = 4'hF;
        wait_row_start(row);
        repeat (3) tick();
        swc = col;
        repeat (hold) tick();
        swc = 4'hF;
        repeat (rel) tick();
    endtask

    typedef struct {
        logic [3:0] row;
        logic [3:0] col;
        int         code;
    } vec_t;

    vec_t tbl[6];

    initial begin
        int         k_row;
        logic [3:0] k_col;
        int         k_left;

        tbl[0] = '{4'b0111, 4'b0111, 0};
        tbl[1] = '{4'b1110, 4'b1110, 15};
        tbl[2] = '{4'b1101, 4'b1011, 9};
        tbl[3] = '{4'b1011, 4'b1101, 6};
        tbl[4] = '{4'b0111, 4'b1110, 3};
        tbl[5] = '{4'b1110, 4'b0111, 12};

        // Reset values
        rst_n = 1'b0;
        repeat (3) tick();
        chk("rst_swr", int'(swr), 7);
        chk("rst_key_code", int'(key_code), 0);
        chk("rst_key_valid", int'(key_valid), 0);
        chk("rst_key_down", int'(key_down), 0);
        chk("rst_overrun", int'(overrun), 0);
        rst_n = 1'b1;

        // Table of single presses with a ready consumer
        key_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            got_q.delete();
            press(tbl[i].row, tbl[i].col, 30, 12);
            chk("tbl_push_count", got_q.size(), 1);
            chk("tbl_code", got_q.size() > 0 ? got_q[0] : -1, tbl[i].code);
        end

        // Bounce: three matching clocks then release
        got_q.delete();
        swc = 4'hF;
        wait_row_start(4'b0111);
        repeat (3) tick();
        swc = 4'b1110;
        repeat (3) tick();
        swc = 4'hF;
        tick();
        chk("bounce_swr", int'(swr), 4'b1011);
        chk("bounce_key_down", int'(key_down), 0);
        repeat (20) tick();
        chk("bounce_no_push", got_q.size(), 0);

        // Two columns low keeps scanning
        wait_row_start(4'b0111);
        swc = 4'b1100;
        repeat (4) tick();
        chk("twocol_swr1", int'(swr), 4'b1011);
        repeat (4) tick();
        chk("twocol_swr2", int'(swr), 4'b1101);
        chk("twocol_key_down", int'(key_down), 0);
        swc = 4'hF;

`ifndef KEYPAD_SCAN_KEY_FIFO_EN
        // Overrun with a stalled consumer; drop outranks a clear
        key_ready = 1'b0;
        got_q.delete();
        press(4'b0111, 4'b0111, 20, 12);
        press(4'b1110, 4'b1110, 20, 12);
        chk("ovr_key_code", int'(key_code), 0);
        chk("ovr_key_valid", int'(key_valid), 1);
        chk("ovr_set", int'(overrun), 1);
        wait_row_start(4'b1101);
        repeat (3) tick();
        swc = 4'b1011;
        tick();
        repeat (6) tick();
        ovr_clr = 1'b1;
        tick();
        chk("ovr_cleared", int'(overrun), 0);
        tick();
        chk("ovr_drop_beats_clr", int'(overrun), 1);
        ovr_clr = 1'b0;
        swc = 4'hF;
        repeat (12) tick();
        chk("ovr_sticky", int'(overrun), 1);
        chk("ovr_code_held", int'(key_code), 0);
        ovr_clr = 1'b1;
        tick();
        ovr_clr = 1'b0;
        chk("ovr_clr_alone", int'(overrun), 0);
        key_ready = 1'b1;
        repeat (3) tick();
        chk("ovr_drain_count", got_q.size(), 1);
        chk("ovr_drain_code", got_q.size() > 0 ? got_q[0] : -1, 0);
`else
        // FIFO fills with four keys, fifth is dropped, then drains in order
        key_ready = 1'b0;
        press(4'b0111, 4'b1011, 20, 12);
        press(4'b0111, 4'b1101, 20, 12);
        press(4'b0111, 4'b1110, 20, 12);
        press(4'b1011, 4'b0111, 20, 12);
        press(4'b1011, 4'b1011, 20, 12);
        chk("fifo_ovr", int'(overrun), 1);
        chk("fifo_head", int'(key_code), 1);
        got_q.delete();
        key_ready = 1'b1;
        repeat (6) tick();
        chk("fifo_drain_count", got_q.size(), 4);
        for (int i = 0; i < 4; i++)
            chk("fifo_order", got_q.size() > i ? got_q[i] : -1, i + 1);
`endif

        // Reset while holding abandons the key
        key_ready = 1'b0;
        ovr_clr = 1'b1;
        tick();
        ovr_clr = 1'b0;
        got_q.delete();
        wait_row_start(4'b1101);
        repeat (3) tick();
        swc = 4'b1011;
        repeat (15) tick();
        chk("hold_key_down", int'(key_down), 1);
        rst_n = 1'b0;
        swc = 4'hF;
        tick();
        rst_n = 1'b1;
        chk("hrst_swr", int'(swr), 7);
        chk("hrst_key_valid", int'(key_valid), 0);
        chk("hrst_key_down", int'(key_down), 0);
        chk("hrst_key_code", int'(key_code), 0);
        chk("hrst_overrun", int'(overrun), 0);
        key_ready = 1'b1;
        repeat (20) tick();
        chk("hrst_no_push", got_q.size(), 0);

        // Randomized keypad activity against the model
        k_row = -1;
        k_col = 4'hF;
        k_left = 0;
        for (int k = 0; k < 3000; k++) begin
            if (k_left == 0 && $urandom_range(0, 29) == 0) begin
                k_row  = int'($urandom_range(0, 3));
                k_col  = row_pat(int'($urandom_range(0, 3)));
                k_left = int'($urandom_range(4, 40));
            end
            if (k_left > 0 && swr == row_pat(k_row)) swc = k_col;
            else swc = 4'hF;
            if ($urandom_range(0, 49) == 0) swc = 4'($urandom);
            key_ready = ($urandom_range(0, 3) != 0);
            ovr_clr   = ($urandom_range(0, 39) == 0);
            rst_n     = ($urandom_range(0, 999) != 0);
            tick();
            if (k_left > 0) k_left--;
        end
        rst_n = 1'b1;
        ovr_clr = 1'b0;
        swc = 4'hF;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
